// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M-style multiply/divide unit that computes one bit per cycle.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               synchronous abort of any operation; also discards a held result
//   in_valid/in_ready   request handshake; in_ready is high only in IDLE
//   fnc3                000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                       100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1, rs2            dividend/multiplicand and divisor/multiplier
//   out_valid/out_ready result handshake; rd is held until out_ready is sampled high
//   rd                  registered result
module alu_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      fnc3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd
);

   localparam int              CW       = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_r;
   logic [2:0]          fnc_r;
   logic                neg_a_r;
   logic                neg_b_r;
   logic [XLEN-1:0]     mcand_r;    // multiplicand magnitude, or divisor magnitude
   logic [2*XLEN-1:0]   acc_r;      // {hi, lo}: product, or {remainder, quotient}
   logic [CW-1:0]       cnt_r;
   logic [XLEN-1:0]     rd_r;
   logic                out_valid_r;

   logic                sgn_a_s;
   logic                sgn_b_s;
   logic                neg_a_s;
   logic                neg_b_s;
   logic [XLEN-1:0]     mag_a_s;
   logic [XLEN-1:0]     mag_b_s;
   logic                div_zero_s;
   logic [XLEN-1:0]     dz_res_s;
   logic [XLEN:0]       mul_sum_s;
   logic [2*XLEN-1:0]   mul_next_s;
   logic [XLEN:0]       div_trial_s;
   logic [XLEN:0]       div_diff_s;
   logic                div_ge_s;
   logic [2*XLEN-1:0]   div_next_s;
   logic [2*XLEN-1:0]   prod_s;
   logic [XLEN-1:0]     quo_s;
   logic [XLEN-1:0]     rem_s;
   logic [XLEN-1:0]     fix_s;

   assign in_ready  = (state_r == IDLE);
   assign out_valid = out_valid_r;
   assign rd        = rd_r;

   // Operand signedness and magnitudes at the accept edge. MUL is treated as
   // unsigned since its low half does not depend on operand signedness.
   assign sgn_a_s    = (fnc3 == 3'b001) | (fnc3 == 3'b010) | (fnc3 == 3'b100) | (fnc3 == 3'b110);
   assign sgn_b_s    = (fnc3 == 3'b001) | (fnc3 == 3'b100) | (fnc3 == 3'b110);
   assign neg_a_s    = sgn_a_s & rs1[XLEN-1];
   assign neg_b_s    = sgn_b_s & rs2[XLEN-1];
   assign mag_a_s    = neg_a_s ? ({XLEN{1'b0}} - rs1) : rs1;
   assign mag_b_s    = neg_b_s ? ({XLEN{1'b0}} - rs2) : rs2;
   assign div_zero_s = fnc3[2] & (rs2 == {XLEN{1'b0}});
   assign dz_res_s   = fnc3[1] ? rs1 : {XLEN{1'b1}};

   // Shift-add step: multiplier sits in the low half and is consumed LSB first.
   assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
   assign mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};

   // Restoring divide step: shift the next dividend bit into the partial
   // remainder, keep the difference only if it did not go negative.
   assign div_trial_s = acc_r[2*XLEN-1:XLEN-1];
   assign div_diff_s  = div_trial_s - {1'b0, mcand_r};
   assign div_ge_s    = ~div_diff_s[XLEN];
   assign div_next_s  = {(div_ge_s ? div_diff_s[XLEN-1:0] : div_trial_s[XLEN-1:0]),
                         acc_r[XLEN-2:0], div_ge_s};

   assign prod_s = (neg_a_r ^ neg_b_r) ? ({(2*XLEN){1'b0}} - acc_r) : acc_r;
   assign quo_s  = acc_r[XLEN-1:0];
   assign rem_s  = acc_r[2*XLEN-1:XLEN];

   // Sign correction and result selection applied in FIX.
   always_comb begin
      fix_s = {XLEN{1'b0}};
      case (fnc_r)
         3'b000:                fix_s = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_s = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:        fix_s = (neg_a_r ^ neg_b_r) ? ({XLEN{1'b0}} - quo_s) : quo_s;
         3'b110, 3'b111:        fix_s = neg_a_r ? ({XLEN{1'b0}} - rem_s) : rem_s;
         default:               fix_s = {XLEN{1'b0}};
      endcase
   end

   // Control FSM together with the datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         fnc_r       <= 3'b000;
         neg_a_r     <= 1'b0;
         neg_b_r     <= 1'b0;
         mcand_r     <= {XLEN{1'b0}};
         acc_r       <= {(2*XLEN){1'b0}};
         cnt_r       <= {CW{1'b0}};
         rd_r        <= {XLEN{1'b0}};
         out_valid_r <= 1'b0;
      end else if (flush) begin
         state_r     <= IDLE;
         cnt_r       <= {CW{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  fnc_r   <= fnc3;
                  neg_a_r <= neg_a_s;
                  neg_b_r <= neg_b_s;
                  mcand_r <= fnc3[2] ? mag_b_s : mag_a_s;
                  acc_r   <= {{XLEN{1'b0}}, (fnc3[2] ? mag_a_s : mag_b_s)};
                  cnt_r   <= {CW{1'b0}};
                  if (div_zero_s) begin
                     rd_r        <= dz_res_s;
                     out_valid_r <= 1'b1;
                     state_r     <= DONE;
                  end else begin
                     state_r <= CALC;
                  end
               end
            end
            CALC: begin
               acc_r <= fnc_r[2] ? div_next_s : mul_next_s;
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= {CW{1'b0}};
                  state_r <= FIX;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            FIX: begin
               rd_r        <= fix_s;
               out_valid_r <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed and randomised checks of alu_muldiv at XLEN=32 and XLEN=16.
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, in_valid, out_ready, in_ready, out_valid;
   logic [2:0]  fnc3;
   logic [31:0] rs1, rs2, rd;

   logic        flush_16, in_valid_16, out_ready_16, in_ready_16, out_valid_16;
   logic [2:0]  fnc3_16;
   logic [15:0] rs1_16, rs2_16, rd_16;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_muldiv #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .fnc3(fnc3), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready), .rd(rd)
   );

   alu_muldiv #(.XLEN(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .flush(flush_16), .in_valid(in_valid_16), .in_ready(in_ready_16),
      .fnc3(fnc3_16), .rs1(rs1_16), .rs2(rs2_16), .out_valid(out_valid_16),
      .out_ready(out_ready_16), .rd(rd_16)
   );

   // Behavioural reference using 64-bit arithmetic.
   function automatic logic [63:0] model(input int xl, input logic [2:0] f,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [63:0] mask, p;
      longint sa, sb, ua, ub, q;
      mask = (64'd1 << xl) - 64'd1;
      ua = longint'(a & mask);
      ub = longint'(b & mask);
      sa = a[xl-1] ? longint'(a | ~mask) : ua;
      sb = b[xl-1] ? longint'(b | ~mask) : ub;
      case (f)
         3'd0: begin q = sa * sb; p = q; return p & mask; end
         3'd1: begin q = sa * sb; p = q; return (p >> xl) & mask; end
         3'd2: begin q = sa * ub; p = q; return (p >> xl) & mask; end
         3'd3: begin q = ua * ub; p = q; return (p >> xl) & mask; end
         3'd4: begin if (ub == 0) return mask; q = sa / sb; p = q; return p & mask; end
         3'd5: begin if (ub == 0) return mask; q = ua / ub; p = q; return p & mask; end
         3'd6: begin if (ub == 0) return a & mask; q = sa % sb; p = q; return p & mask; end
         default: begin if (ub == 0) return a & mask; q = ua % ub; p = q; return p & mask; end
      endcase
   endfunction

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [15:0] pick16();
      case ($urandom_range(0, 6))
         0: return 16'h0;
         1: return 16'h1;
         2: return 16'hFFFF;
         3: return 16'h8000;
         4: return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Presents one request, then scrambles the inputs after the accept edge.
   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      fnc3 = f; rs1 = a; rs2 = b; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      fnc3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
   endtask

   // Cycles from accept until out_valid is seen; -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      start_op(f, a, b);
      wait_done(lat);
      if (lat >= 0) begin
         res = rd;
         finish_op();
      end else begin
         res = 'x;
         flush = 1'b1;
         @(posedge clk);
         #1;
         flush = 1'b0;
      end
   endtask

   task automatic do_op16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output int lat);
      @(negedge clk);
      fnc3_16 = f; rs1_16 = a; rs2_16 = b; in_valid_16 = 1'b1;
      @(posedge clk);
      #1;
      in_valid_16 = 1'b0;
      rs1_16 = 16'($urandom); rs2_16 = 16'($urandom);
      lat = -1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (out_valid_16 === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat >= 0) begin
         res = rd_16;
         out_ready_16 = 1'b1;
         @(posedge clk);
         #1;
         out_ready_16 = 1'b0;
      end else begin
         res = 'x;
         flush_16 = 1'b1;
         @(posedge clk);
         #1;
         flush_16 = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fnc3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
      flush_16 = 1'b0; in_valid_16 = 1'b0; out_ready_16 = 1'b0; fnc3_16 = 3'd0;
      rs1_16 = 16'd0; rs2_16 = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      tests++;
      if (rd !== 32'd0) begin fails++; $display("FAIL reset_rd got=%h exp=0", rd); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mul();
      logic [31:0] r;
      int lat;
      do_op(3'd0, 32'h00000007, 32'hFFFFFFFD, r, lat);
      tests++;
      if (r !== 32'hFFFFFFEB) begin fails++; $display("FAIL mul got=%h exp=ffffffeb", r); end
      tests++;
      if (lat != 33) begin fails++; $display("FAIL mul_latency got=%0d exp=33", lat); end
      do_op(3'd1, 32'h00000007, 32'hFFFFFFFD, r, lat);
      tests++;
      if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL mulh got=%h exp=ffffffff", r); end
      do_op(3'd3, 32'h00000007, 32'hFFFFFFFD, r, lat);
      tests++;
      if (r !== 32'h00000006) begin fails++; $display("FAIL mulhu got=%h exp=00000006", r); end
      do_op(3'd2, 32'hFFFFFFFD, 32'h00000007, r, lat);
      tests++;
      if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
   endtask

   task automatic test_div();
      logic [31:0] r;
      int lat;
      do_op(3'd4, 32'hFFFFFFF9, 32'h00000002, r, lat);
      tests++;
      if (r !== 32'hFFFFFFFD) begin fails++; $display("FAIL div got=%h exp=fffffffd", r); end
      tests++;
      if (lat != 33) begin fails++; $display("FAIL div_latency got=%0d exp=33", lat); end
      do_op(3'd6, 32'hFFFFFFF9, 32'h00000002, r, lat);
      tests++;
      if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL rem got=%h exp=ffffffff", r); end
      do_op(3'd5, 32'hFFFFFFF9, 32'h00000002, r, lat);
      tests++;
      if (r !== 32'h7FFFFFFC) begin fails++; $display("FAIL divu got=%h exp=7ffffffc", r); end
      do_op(3'd7, 32'hFFFFFFF9, 32'h00000002, r, lat);
      tests++;
      if (r !== 32'h00000001) begin fails++; $display("FAIL remu got=%h exp=00000001", r); end
   endtask

   task automatic test_corner();
      logic [31:0] r;
      int lat;
      do_op(3'd4, 32'd5, 32'd0, r, lat);
      tests++;
      if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_by_zero got=%h exp=ffffffff", r); end
      tests++;
      if (lat != 1) begin fails++; $display("FAIL div_by_zero_latency got=%0d exp=1", lat); end
      do_op(3'd6, 32'd5, 32'd0, r, lat);
      tests++;
      if (r !== 32'd5) begin fails++; $display("FAIL rem_by_zero got=%h exp=00000005", r); end
      do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, r, lat);
      tests++;
      if (r !== 32'h80000000) begin fails++; $display("FAIL div_overflow got=%h exp=80000000", r); end
      do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, r, lat);
      tests++;
      if (r !== 32'h00000000) begin fails++; $display("FAIL rem_overflow got=%h exp=00000000", r); end
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(3'd3, 32'h00000007, 32'hFFFFFFFD);
      wait_done(lat);
      tests++;
      if (rd !== 32'h00000006) begin fails++; $display("FAIL bp_result got=%h exp=00000006", rd); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         tests++;
         if ({out_valid, in_ready, rd} !== {1'b1, 1'b0, 32'h00000006}) begin
            fails++;
            $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b rd=%h exp valid=1 ready=0 rd=00000006",
                     i, out_valid, in_ready, rd);
         end
      end
      finish_op();
      tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         fails++; $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
      end
   endtask

   task automatic test_input_hold();
      logic [31:0] r;
      logic [63:0] e;
      int lat;
      // do_op scrambles rs1/rs2/fnc3 right after the accept edge
      do_op(3'd5, 32'hDEADBEEF, 32'h00001234, r, lat);
      e = model(32, 3'd5, {32'd0, 32'hDEADBEEF}, {32'd0, 32'h00001234});
      tests++;
      if (r !== e[31:0]) begin fails++; $display("FAIL input_hold_divu got=%h exp=%h", r, e[31:0]); end
      do_op(3'd1, 32'h89ABCDEF, 32'h76543210, r, lat);
      e = model(32, 3'd1, {32'd0, 32'h89ABCDEF}, {32'd0, 32'h76543210});
      tests++;
      if (r !== e[31:0]) begin fails++; $display("FAIL input_hold_mulh got=%h exp=%h", r, e[31:0]); end
   endtask

   task automatic test_flush();
      logic seen;
      start_op(3'd4, 32'h12345678, 32'h00000003);
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         fails++; $display("FAIL flush_calc got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0) begin fails++; $display("FAIL flush_no_result got seen=%b exp=0", seen); end
      // flush must win over a simultaneous request in IDLE
      @(negedge clk);
      fnc3 = 3'd5; rs1 = 32'd5; rs2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0;
      tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         fails++; $display("FAIL flush_vs_accept got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      int lat;
      do_op(3'd0, 32'd7, 32'd3, r, lat);
      tests++;
      if (r !== 32'd21) begin fails++; $display("FAIL pre_reset_mul got=%h exp=00000015", r); end
      start_op(3'd0, 32'd9, 32'd9);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests++;
      if ({out_valid, in_ready, rd} !== {1'b0, 1'b1, 32'd0}) begin
         fails++;
         $display("FAIL async_reset got valid=%b ready=%b rd=%h exp valid=0 ready=1 rd=00000000",
                  out_valid, in_ready, rd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(3'd0, 32'd9, 32'd9, r, lat);
      tests++;
      if (r !== 32'd81 || lat != 33) begin
         fails++; $display("FAIL post_reset_mul got=%h lat=%0d exp=00000051 lat=33", r, lat);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, r;
      logic [2:0]  f;
      logic [63:0] e;
      int lat, elat;
      for (int n = 0; n < 200; n++) begin
         f = 3'($urandom);
         a = pick32();
         b = pick32();
         do_op(f, a, b, r, lat);
         e = model(32, f, {32'd0, a}, {32'd0, b});
         elat = (f[2] && b == 32'd0) ? 1 : 33;
         tests++;
         if (r !== e[31:0] || lat != elat) begin
            fails++;
            $display("FAIL random32 n=%0d f=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=%0d",
                     n, f, a, b, r, lat, e[31:0], elat);
         end
      end
   endtask

   task automatic test_xlen16();
      logic [15:0] a, b, r;
      logic [2:0]  f;
      logic [63:0] e;
      int lat, elat;
      do_op16(3'd1, 16'h0007, 16'hFFFD, r, lat);
      tests++;
      if (r !== 16'hFFFF || lat != 17) begin
         fails++; $display("FAIL x16_mulh got=%h lat=%0d exp=ffff lat=17", r, lat);
      end
      do_op16(3'd4, 16'h8000, 16'hFFFF, r, lat);
      tests++;
      if (r !== 16'h8000) begin fails++; $display("FAIL x16_div_overflow got=%h exp=8000", r); end
      for (int n = 0; n < 60; n++) begin
         f = 3'($urandom);
         a = pick16();
         b = pick16();
         do_op16(f, a, b, r, lat);
         e = model(16, f, {48'd0, a}, {48'd0, b});
         elat = (f[2] && b == 16'd0) ? 1 : 17;
         tests++;
         if (r !== e[15:0] || lat != elat) begin
            fails++;
            $display("FAIL random16 n=%0d f=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=%0d",
                     n, f, a, b, r, lat, e[15:0], elat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_corner();
      test_backpressure();
      test_input_hold();
      test_flush();
      test_reset_mid();
      test_random();
      test_xlen16();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not complete tests=%0d", tests);
      $fatal(1);
   end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative, parametrised multiply/divide unit implementing the RV32M function set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for any even XLEN. It sits beside the single-cycle integer ALU in the execute stage. It takes operands through a valid/ready handshake, computes one bit per cycle, and holds its result until the consumer accepts it. A flush input lets the pipeline kill an in-flight operation on a branch or trap.

## Interface
- XLEN, 32: operand and result width; even, ≥ 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  abort any operation; synchronous.
- in_valid  in  1  request carries a valid operation.
- in_ready  out  1  unit can accept; high only in IDLE.
- fnc3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  dividend / multiplicand.
- rs2  in  XLEN  divisor / multiplier.
- out_valid  out  1  rd holds a finished result.
- out_ready  in  1  consumer takes the result.
- rd  out  XLEN  result, registered.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept:
  - Occurs when in_valid & in_ready & !flush at a clock edge.
  - fnc3, rs1 and rs2 are latched at that edge; later input changes are ignored.
- Signedness:
  - Each operand is signed or unsigned per fnc3.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - Signed operands are converted to magnitude at accept, and the sign of each is recorded.
- Multiply:
  - Shift-add over a 2·XLEN accumulator, one multiplier bit per CALC cycle.
  - FIX negates the 2·XLEN product if the operand signs differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Restoring divide, one quotient bit per CALC cycle, producing an XLEN quotient and an XLEN remainder.
  - FIX negates the quotient if the dividend and divisor signs differ.
  - FIX negates the remainder if the dividend is negative.
- Divide by zero (rs2 == 0, fnc3[2] = 1):
  - Skips CALC and FIX; goes IDLE→DONE directly.
  - Quotient is all-ones; remainder is rs1.
- Signed overflow (DIV/REM with rs1 = −2^(XLEN−1), rs2 = −1):
  - Quotient = rs1, remainder = 0.
  - This falls out of the magnitude algorithm; no special path.
- Iteration counter: counts 0..XLEN−1 in CALC, width clog2(XLEN); CALC→FIX when the count reaches XLEN−1.
- DONE:
  - out_valid = 1 and rd is held stable until out_ready is sampled high.
  - DONE→IDLE on that edge.
- flush:
  - At any edge, forces state to IDLE and out_valid to 0; any result in DONE is discarded.
  - flush with in_valid in IDLE: flush wins, no accept.
- Reset state: state IDLE, out_valid 0, rd 0, counter 0; in_ready is 1 once in IDLE.

## Timing
- Accept at edge E:
  - Normal operations: CALC occupies edges E+1..E+XLEN, FIX resolves at edge E+XLEN+1, and out_valid rises after edge E+XLEN+1. Latency is XLEN+1 cycles (33 at XLEN=32).
  - Divide by zero: out_valid rises after edge E+1.
- in_ready is a combinational decode of state == IDLE; it does not depend on in_valid.
- Earliest next accept: the edge after the out_valid/out_ready handshake. Peak throughput is one operation per XLEN+3 cycles.
- out_ready is ignored outside DONE.
- rd changes only at the FIX→DONE or IDLE→DONE transition.
- rst_n low asynchronously clears all state, including mid-CALC; the unit resumes in IDLE after the first edge with rst_n high.

## Test plan
- Multiplies, XLEN=32: rs1 = 0x00000007, rs2 = 0xFFFFFFFD:
  - MUL → 0xFFFFFFEB.
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000006.
  - MULHSU with rs1 = 0xFFFFFFFD, rs2 = 7 → 0xFFFFFFFF.
  - out_valid rises exactly 33 cycles after accept.
- Divides, rs1 = 0xFFFFFFF9, rs2 = 2:
  - DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC; REMU → 0x00000001.
- Corner cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; out_valid after 1 cycle.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Backpressure and input hold:
  - Hold out_ready low for 5 cycles in DONE: rd stable, out_valid high, in_ready low.
  - Toggle rs1/rs2 after accept: result unaffected.
- Abort and reset:
  - flush in CALC cycle 10 → IDLE next edge, in_ready 1, out_valid never asserts.
  - rst_n pulsed low mid-CALC → out_valid 0 and rd 0 immediately, without waiting for a clock edge.
- Randomised check: 200 operations with random fnc3 and operands, compared against a behavioural 64-bit model; XLEN=16 instance also run.
